// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse-length producer/consumer family:
// state encoding, default width and the control-to-datapath command word.
package pulse_meter_pkg;

    localparam int unsigned DefaultWidth = 8;

    localparam logic [2:0] S_ARM      = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_COUNT    = 3'd2;
    localparam logic [2:0] S_WAIT_RFD = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;

    typedef enum logic [2:0] {
        StArm     = S_ARM,
        StIdle    = S_IDLE,
        StCount   = S_COUNT,
        StWaitRfd = S_WAIT_RFD,
        StWaitAck = S_WAIT_ACK
    } state_e;

    typedef struct packed {
        logic cnt_load;
        logic cnt_inc;
        logic z_load;
        logic dav_clr;
        logic dav_set;
    } cmd_t;

endpackage

// File: rtl/pulse_meter_if.sv
// Pulse line plus dav_/rfd handshake bus. The master side is the pulse_meter
// (handshake producer); the slave side is the downstream consumer.
interface pulse_meter_if
    import pulse_meter_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) ();

    logic         in;
    logic         rfd;
    logic         dav_;
    logic [W-1:0] z;

    modport master (
        input  in,
        input  rfd,
        output dav_,
        output z
    );

    modport slave (
        output in,
        output rfd,
        input  dav_,
        input  z
    );

endinterface

// File: rtl/pulse_meter_sat_inc.sv
// W-bit saturating incrementer; max_o flags an all-ones input, which is held.
module pulse_meter_sat_inc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o,
    output logic         max_o
);

    always_comb begin
        max_o = &a_i;
        y_o   = max_o ? a_i : a_i + W'(1);
    end

endmodule

// File: rtl/pulse_meter.sv
// Pulse-length decoder: counts posedges with `in` high and hands the count to
// a consumer over the active-low dav_ / rfd handshake.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned W = DefaultWidth
) (
    input  logic      clock,
    input  logic      reset_,
    pulse_meter_if.master bus
);

    // Control part state and command word.
    state_e star_q, star_d;
    cmd_t   cmd;

    // Operative part registers and status.
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] z_q, z_d;
    logic         dav_q, dav_d;
    logic [W-1:0] cnt_next;
    logic         cnt_max;
    logic         in_s;
    logic         rfd_s;

    assign in_s  = bus.in;
    assign rfd_s = bus.rfd;

    pulse_meter_sat_inc #(
        .W (W)
    ) u_sat_inc (
        .a_i   (cnt_q),
        .y_o   (cnt_next),
        .max_o (cnt_max)
    );

    // ------------------------------------------------------------------
    // Control part
    // ------------------------------------------------------------------
    always_comb begin
        star_d = star_q;
        cmd    = '0;
        unique case (star_q)
            // Re-arm only on a low line so a pulse already in flight is skipped.
            StArm: begin
                if (!in_s) star_d = StIdle;
            end
            StIdle: begin
                if (in_s) begin
                    cmd.cnt_load = 1'b1;
                    star_d       = StCount;
                end
            end
            StCount: begin
                if (in_s) begin
                    cmd.cnt_inc = !cnt_max;
                end else begin
                    cmd.z_load = 1'b1;
                    star_d     = StWaitRfd;
                end
            end
            StWaitRfd: begin
                if (rfd_s) begin
                    cmd.dav_clr = 1'b1;
                    star_d      = StWaitAck;
                end
            end
            StWaitAck: begin
                if (!rfd_s) begin
                    cmd.dav_set = 1'b1;
                    star_d      = StArm;
                end
            end
            default: star_d = StArm;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            star_q <= StArm;
        end else begin
            star_q <= star_d;
        end
    end

    // ------------------------------------------------------------------
    // Operative part
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (cmd.cnt_load) begin
            cnt_d = W'(1);
        end else if (cmd.cnt_inc) begin
            cnt_d = cnt_next;
        end

        z_d = z_q;
        if (cmd.z_load) z_d = cnt_q;

        dav_d = dav_q;
        if (cmd.dav_clr) begin
            dav_d = 1'b0;
        end else if (cmd.dav_set) begin
            dav_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
            z_q   <= '0;
            dav_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            z_q   <= z_d;
            dav_q <= dav_d;
        end
    end

    assign bus.dav_ = dav_q;
    assign bus.z    = z_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: each task drives a scenario and checks
// dav_/z against hand-computed values one time unit after the clock edge.
module tb_pulse_meter;

    logic clock;
    logic reset_;
    int   tests_run;
    int   tests_failed;

    pulse_meter_if #(.W(8)) bus ();

    pulse_meter #(
        .W (8)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        bus.in = 1'b0;
        bus.rfd = 1'b0;
        cyc(2);
        tests_run++;
        if (bus.dav_ !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_dav: actual=%b required=1", bus.dav_);
        end
        tests_run++;
        if (bus.z !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_z: actual=%0d required=0", bus.z);
        end
        reset_ = 1'b1;
        cyc(1);
    endtask

    task automatic test_basic();
        bus.rfd = 1'b1;
        bus.in = 1'b1;
        cyc(5);
        bus.in = 1'b0;
        cyc(1);
        tests_run++;
        if (bus.z !== 8'd5 || bus.dav_ !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_capture: actual z=%0d dav_=%b required z=5 dav_=1", bus.z, bus.dav_);
        end
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b0 || bus.z !== 8'd5) begin
            tests_failed++;
            $display("FAIL basic_dav_fall: actual z=%0d dav_=%b required z=5 dav_=0", bus.z, bus.dav_);
        end
        bus.rfd = 1'b0;
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b1 || bus.z !== 8'd5) begin
            tests_failed++;
            $display("FAIL basic_dav_rise: actual z=%0d dav_=%b required z=5 dav_=1", bus.z, bus.dav_);
        end
    endtask

    task automatic test_one_cycle();
        cyc(1);
        bus.in = 1'b1;
        cyc(1);
        bus.in = 1'b0;
        cyc(1);
        tests_run++;
        if (bus.z !== 8'd1 || bus.dav_ !== 1'b1) begin
            tests_failed++;
            $display("FAIL one_cycle_z: actual z=%0d dav_=%b required z=1 dav_=1", bus.z, bus.dav_);
        end
        bus.rfd = 1'b1;
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b0) begin
            tests_failed++;
            $display("FAIL one_cycle_dav: actual=%b required=0", bus.dav_);
        end
        bus.rfd = 1'b0;
        cyc(1);
    endtask

    task automatic test_saturate();
        cyc(1);
        bus.in = 1'b1;
        cyc(300);
        bus.in = 1'b0;
        cyc(1);
        tests_run++;
        if (bus.z !== 8'd255) begin
            tests_failed++;
            $display("FAIL saturate_z: actual=%0d required=255", bus.z);
        end
        bus.rfd = 1'b1;
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b0 || bus.z !== 8'd255) begin
            tests_failed++;
            $display("FAIL saturate_dav: actual z=%0d dav_=%b required z=255 dav_=0", bus.z, bus.dav_);
        end
        bus.rfd = 1'b0;
        cyc(1);
    endtask

    task automatic test_stall();
        cyc(1);
        bus.in = 1'b1;
        cyc(2);
        bus.in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            tests_run++;
            if (bus.dav_ !== 1'b1 || bus.z !== 8'd2) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: actual z=%0d dav_=%b required z=2 dav_=1", i, bus.z, bus.dav_);
            end
        end
        bus.rfd = 1'b1;
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_release: actual=%b required=0", bus.dav_);
        end
        bus.rfd = 1'b0;
        cyc(1);
    endtask

    task automatic test_ack_hold();
        cyc(1);
        bus.in = 1'b1;
        cyc(6);
        bus.in = 1'b0;
        cyc(1);
        bus.rfd = 1'b1;
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b0 || bus.z !== 8'd6) begin
            tests_failed++;
            $display("FAIL ack_enter: actual z=%0d dav_=%b required z=6 dav_=0", bus.z, bus.dav_);
        end
        // Pulse arrives while the consumer still holds rfd high.
        for (int i = 0; i < 4; i++) begin
            bus.in = (i < 3);
            cyc(1);
            tests_run++;
            if (bus.dav_ !== 1'b0 || bus.z !== 8'd6) begin
                tests_failed++;
                $display("FAIL ack_hold[%0d]: actual z=%0d dav_=%b required z=6 dav_=0", i, bus.z, bus.dav_);
            end
        end
        bus.in = 1'b0;
        bus.rfd = 1'b0;
        cyc(1);
        bus.rfd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            tests_run++;
            if (bus.dav_ !== 1'b1 || bus.z !== 8'd6) begin
                tests_failed++;
                $display("FAIL ack_lost_pulse[%0d]: actual z=%0d dav_=%b required z=6 dav_=1", i, bus.z, bus.dav_);
            end
        end
        bus.rfd = 1'b0;
    endtask

    task automatic test_high_across_reset();
        bus.in = 1'b1;
        reset_ = 1'b0;
        #1;
        tests_run++;
        if (bus.dav_ !== 1'b1 || bus.z !== 8'd0) begin
            tests_failed++;
            $display("FAIL arm_reset: actual z=%0d dav_=%b required z=0 dav_=1", bus.z, bus.dav_);
        end
        cyc(1);
        reset_ = 1'b1;
        bus.rfd = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            tests_run++;
            if (bus.dav_ !== 1'b1 || bus.z !== 8'd0) begin
                tests_failed++;
                $display("FAIL arm_skip[%0d]: actual z=%0d dav_=%b required z=0 dav_=1", i, bus.z, bus.dav_);
            end
        end
        bus.in = 1'b0;
        cyc(1);
        bus.in = 1'b1;
        cyc(4);
        bus.in = 1'b0;
        cyc(1);
        tests_run++;
        if (bus.z !== 8'd4 || bus.dav_ !== 1'b1) begin
            tests_failed++;
            $display("FAIL arm_clean_z: actual z=%0d dav_=%b required z=4 dav_=1", bus.z, bus.dav_);
        end
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b0 || bus.z !== 8'd4) begin
            tests_failed++;
            $display("FAIL arm_clean_dav: actual z=%0d dav_=%b required z=4 dav_=0", bus.z, bus.dav_);
        end
        bus.rfd = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid();
        // Interrupt a count after 3 of 6 high cycles.
        cyc(1);
        bus.in = 1'b1;
        cyc(3);
        reset_ = 1'b0;
        #1;
        tests_run++;
        if (bus.dav_ !== 1'b1 || bus.z !== 8'd0) begin
            tests_failed++;
            $display("FAIL midcount_reset: actual z=%0d dav_=%b required z=0 dav_=1", bus.z, bus.dav_);
        end
        cyc(1);
        reset_ = 1'b1;
        cyc(2);
        bus.in = 1'b0;
        bus.rfd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            tests_run++;
            if (bus.dav_ !== 1'b1 || bus.z !== 8'd0) begin
                tests_failed++;
                $display("FAIL midcount_no_xfer[%0d]: actual z=%0d dav_=%b required z=0 dav_=1", i, bus.z, bus.dav_);
            end
        end
        bus.rfd = 1'b0;
        // Interrupt a pending transfer with dav_ low.
        bus.in = 1'b1;
        cyc(2);
        bus.in = 1'b0;
        cyc(1);
        bus.rfd = 1'b1;
        cyc(1);
        tests_run++;
        if (bus.dav_ !== 1'b0 || bus.z !== 8'd2) begin
            tests_failed++;
            $display("FAIL midxfer_setup: actual z=%0d dav_=%b required z=2 dav_=0", bus.z, bus.dav_);
        end
        reset_ = 1'b0;
        #1;
        tests_run++;
        if (bus.dav_ !== 1'b1 || bus.z !== 8'd0) begin
            tests_failed++;
            $display("FAIL midxfer_reset: actual z=%0d dav_=%b required z=0 dav_=1", bus.z, bus.dav_);
        end
        cyc(1);
        reset_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            tests_run++;
            if (bus.dav_ !== 1'b1 || bus.z !== 8'd0) begin
                tests_failed++;
                $display("FAIL midxfer_no_xfer[%0d]: actual z=%0d dav_=%b required z=0 dav_=1", i, bus.z, bus.dav_);
            end
        end
        bus.rfd = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_one_cycle();
        test_saturate();
        test_stall();
        test_ack_hold();
        test_high_across_reset();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
